mem_access_stage: RTL and testbench

- Memory stage that sits directly downstream of the EX/MEM pipeline latch and consumes its registered outputs: address, read/write strobes, store data, quarter, write and writeReg.
- Performs the data-RAM access through a ready-handshake interface with a bounded wait.
- Stalls the upstream pipeline while an access is outstanding.
- Presents registered results to the writeback stage (MEM/WB side).

---
 rtl/pipeline_pkg.sv | 13 +
 rtl/mem_access_stage_if.sv | 24 ++
 rtl/mem_wait_timer.sv | 24 ++
 rtl/mem_access_stage.sv | 165 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: MEM-stage state encoding and default datapath widths.
package pipeline_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } memState_e;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned REG_W      = 4;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-RAM ready handshake: the stage is master, the RAM is slave.
interface mem_access_stage_if
    import pipeline_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_re;
    logic              ram_we;
    logic              ram_ready;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output ram_addr, ram_wdata, ram_re, ram_we,
        input  ram_ready, ram_rdata
    );

    modport slave (
        input  ram_addr, ram_wdata, ram_re, ram_we,
        output ram_ready, ram_rdata
    );
endinterface

// File: rtl/mem_wait_timer.sv
// 8-bit access wait counter; expired flags the last permitted ACCESS cycle.
module mem_wait_timer #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [7:0] countQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            countQ <= 8'd0;
        end else if (clear) begin
            countQ <= 8'd0;
        end else if (enable) begin
            countQ <= countQ + 8'd1;
        end
    end

    assign expired = (countQ == 8'(MAX_WAIT - 1));
endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one data-RAM access per load/store with a bounded wait,
// stalls upstream while busy, and registers results for writeback.
module mem_access_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] DataAddress,
    input  logic              ReadMem,
    input  logic              WriteMem,
    input  logic [DATA_W-1:0] DataIn,
    input  logic [1:0]        quarter,
    input  logic              write,
    input  logic [REG_W-1:0]  writeReg,
    mem_access_stage_if.master ram,
    output logic              stall,
    output logic [DATA_W-1:0] wb_data,
    output logic [1:0]        wb_quarter,
    output logic              wb_write,
    output logic [REG_W-1:0]  wb_writeReg,
    output logic              mem_err
);
    memState_e         stateQ, stateD;
    logic [ADDR_W-1:0] addrQ, addrD;
    logic [DATA_W-1:0] dataQ, dataD;
    logic              isReadQ, isReadD;
    logic              writeQ, writeD;
    logic [REG_W-1:0]  regQ, regD;
    logic [1:0]        quarterQ, quarterD;
    logic              reQ, reD, weQ, weD;
    logic [DATA_W-1:0] wbDataQ, wbDataD;
    logic [1:0]        wbQuarterQ, wbQuarterD;
    logic              wbWriteQ, wbWriteD;
    logic [REG_W-1:0]  wbRegQ, wbRegD;
    logic              errQ, errD;
    logic              timerClear, timerEn, expired;

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timerClear),
        .enable  (timerEn),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ     <= IDLE;
            addrQ      <= '0;
            dataQ      <= '0;
            isReadQ    <= 1'b0;
            writeQ     <= 1'b0;
            regQ       <= '0;
            quarterQ   <= 2'd0;
            reQ        <= 1'b0;
            weQ        <= 1'b0;
            wbDataQ    <= '0;
            wbQuarterQ <= 2'd0;
            wbWriteQ   <= 1'b0;
            wbRegQ     <= '0;
            errQ       <= 1'b0;
        end else begin
            stateQ     <= stateD;
            addrQ      <= addrD;
            dataQ      <= dataD;
            isReadQ    <= isReadD;
            writeQ     <= writeD;
            regQ       <= regD;
            quarterQ   <= quarterD;
            reQ        <= reD;
            weQ        <= weD;
            wbDataQ    <= wbDataD;
            wbQuarterQ <= wbQuarterD;
            wbWriteQ   <= wbWriteD;
            wbRegQ     <= wbRegD;
            errQ       <= errD;
        end
    end

    always_comb begin
        stateD     = stateQ;
        addrD      = addrQ;
        dataD      = dataQ;
        isReadD    = isReadQ;
        writeD     = writeQ;
        regD       = regQ;
        quarterD   = quarterQ;
        reD        = reQ;
        weD        = weQ;
        wbDataD    = wbDataQ;
        wbQuarterD = wbQuarterQ;
        wbWriteD   = wbWriteQ;
        wbRegD     = wbRegQ;
        errD       = 1'b0;
        timerClear = 1'b0;
        timerEn    = 1'b0;
        case (stateQ)
            IDLE: begin
                timerClear = 1'b1;
                if (ReadMem || WriteMem) begin
                    addrD    = DataAddress;
                    dataD    = DataIn;
                    isReadD  = ReadMem;
                    writeD   = write;
                    regD     = writeReg;
                    quarterD = quarter;
                    // Read wins when both strobes are set; the combination is flagged.
                    reD      = ReadMem;
                    weD      = WriteMem && !ReadMem;
                    errD     = ReadMem && WriteMem;
                    wbWriteD = 1'b0;
                    stateD   = ACCESS;
                end else begin
                    wbDataD    = DATA_W'(DataAddress);
                    wbWriteD   = write;
                    wbRegD     = writeReg;
                    wbQuarterD = quarter;
                end
            end
            ACCESS: begin
                if (ram.ram_ready) begin
                    reD        = 1'b0;
                    weD        = 1'b0;
                    timerClear = 1'b1;
                    stateD     = IDLE;
                    wbDataD    = isReadQ ? ram.ram_rdata : DATA_W'(addrQ);
                    wbWriteD   = writeQ;
                    wbRegD     = regQ;
                    wbQuarterD = quarterQ;
                end else if (expired) begin
                    reD        = 1'b0;
                    weD        = 1'b0;
                    timerClear = 1'b1;
                    stateD     = IDLE;
                    wbDataD    = '0;
                    wbWriteD   = 1'b0;
                    errD       = 1'b1;
                end else begin
                    timerEn  = 1'b1;
                    wbWriteD = 1'b0;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // Reset gates stall so an in-flight request cannot hold upstream during reset.
    assign stall = rst_n && ((stateQ == ACCESS) || ReadMem || WriteMem);

    assign ram.ram_addr  = addrQ;
    assign ram.ram_wdata = dataQ;
    assign ram.ram_re    = reQ;
    assign ram.ram_we    = weQ;
    assign wb_data       = wbDataQ;
    assign wb_quarter    = wbQuarterQ;
    assign wb_write      = wbWriteQ;
    assign wb_writeReg   = wbRegQ;
    assign mem_err       = errQ;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; the bench plays both upstream latch and data RAM.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] DataAddress = '0;
    logic        ReadMem = 1'b0;
    logic        WriteMem = 1'b0;
    logic [15:0] DataIn = '0;
    logic [1:0]  quarter = '0;
    logic        write = 1'b0;
    logic [3:0]  writeReg = '0;
    logic        stall;
    logic [15:0] wb_data;
    logic [1:0]  wb_quarter;
    logic        wb_write;
    logic [3:0]  wb_writeReg;
    logic        mem_err;
    int          vecs = 0;
    int          errs = 0;

    mem_access_stage_if #(.ADDR_W(16), .DATA_W(16)) ramIf ();

    mem_access_stage #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .MAX_WAIT (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .DataAddress (DataAddress),
        .ReadMem     (ReadMem),
        .WriteMem    (WriteMem),
        .DataIn      (DataIn),
        .quarter     (quarter),
        .write       (write),
        .writeReg    (writeReg),
        .ram         (ramIf),
        .stall       (stall),
        .wb_data     (wb_data),
        .wb_quarter  (wb_quarter),
        .wb_write    (wb_write),
        .wb_writeReg (wb_writeReg),
        .mem_err     (mem_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        ReadMem  = 1'b0;
        WriteMem = 1'b0;
        write    = 1'b0;
    endtask

    task automatic test_reset();
        ramIf.ram_ready = 1'b0;
        ramIf.ram_rdata = '0;
        rst_n = 1'b0;
        #2;
        vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL rst_stall got=%b exp=0", stall); end
        vecs++; if (ramIf.ram_re !== 1'b0 || ramIf.ram_we !== 1'b0) begin
            errs++; $display("FAIL rst_strobes got=%b%b exp=00", ramIf.ram_re, ramIf.ram_we); end
        vecs++; if (ramIf.ram_addr !== 16'h0 || ramIf.ram_wdata !== 16'h0) begin
            errs++; $display("FAIL rst_ram_bus got=%h/%h exp=0/0", ramIf.ram_addr, ramIf.ram_wdata); end
        vecs++; if ({wb_data, wb_quarter, wb_write, wb_writeReg, mem_err} !== '0) begin
            errs++; $display("FAIL rst_wb got=%h/%h/%b/%h/%b exp=0", wb_data, wb_quarter, wb_write,
                             wb_writeReg, mem_err); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_nonmem();
        DataAddress = 16'h1234; write = 1'b1; writeReg = 4'd5; quarter = 2'd2;
        #1;
        vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL nonmem_stall got=%b exp=0", stall); end
        tick();
        vecs++; if (wb_data !== 16'h1234) begin
            errs++; $display("FAIL nonmem_data got=%h exp=1234", wb_data); end
        vecs++; if (wb_write !== 1'b1 || wb_writeReg !== 4'd5 || wb_quarter !== 2'd2) begin
            errs++; $display("FAIL nonmem_ctl got=%b/%0d/%0d exp=1/5/2", wb_write, wb_writeReg,
                             wb_quarter); end
        bubble();
    endtask

    task automatic test_load_wait();
        int stallCnt = 0;
        int reCnt = 0;
        DataAddress = 16'h0100; ReadMem = 1'b1; write = 1'b1; writeReg = 4'd3; quarter = 2'd1;
        ramIf.ram_rdata = 16'hBEEF;
        #1;
        if (stall) stallCnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (stall) stallCnt++;
            if (ramIf.ram_re) reCnt++;
            if (i == 0) begin
                vecs++; if (ramIf.ram_addr !== 16'h0100 || wb_write !== 1'b0) begin
                    errs++; $display("FAIL load_access got=%h/%b exp=0100/0", ramIf.ram_addr,
                                     wb_write); end
            end
        end
        ramIf.ram_ready = 1'b1;
        bubble();
        tick();
        ramIf.ram_ready = 1'b0;
        if (stall) stallCnt++;
        if (ramIf.ram_re) reCnt++;
        vecs++; if (stallCnt != 4 || reCnt != 3) begin
            errs++; $display("FAIL load_cycles got=stall%0d/re%0d exp=stall4/re3", stallCnt, reCnt); end
        vecs++; if (wb_data !== 16'hBEEF || wb_write !== 1'b1 || wb_writeReg !== 4'd3 ||
                    wb_quarter !== 2'd1) begin
            errs++; $display("FAIL load_wb got=%h/%b/%0d/%0d exp=beef/1/3/1", wb_data, wb_write,
                             wb_writeReg, wb_quarter); end
    endtask

    task automatic test_store();
        DataAddress = 16'h0040; DataIn = 16'hA5A5; WriteMem = 1'b1; write = 1'b0; writeReg = 4'd7;
        tick();
        vecs++; if (ramIf.ram_we !== 1'b1 || ramIf.ram_re !== 1'b0) begin
            errs++; $display("FAIL store_strobe got=we%b/re%b exp=we1/re0", ramIf.ram_we,
                             ramIf.ram_re); end
        vecs++; if (ramIf.ram_addr !== 16'h0040 || ramIf.ram_wdata !== 16'hA5A5) begin
            errs++; $display("FAIL store_bus got=%h/%h exp=0040/a5a5", ramIf.ram_addr,
                             ramIf.ram_wdata); end
        ramIf.ram_ready = 1'b1;
        bubble();
        tick();
        ramIf.ram_ready = 1'b0;
        vecs++; if (ramIf.ram_we !== 1'b0 || stall !== 1'b0) begin
            errs++; $display("FAIL store_done got=we%b/stall%b exp=0/0", ramIf.ram_we, stall); end
        vecs++; if (wb_write !== 1'b0 || wb_data !== 16'h0040) begin
            errs++; $display("FAIL store_wb got=%b/%h exp=0/0040", wb_write, wb_data); end
    endtask

    task automatic test_timeout();
        int reCnt = 0;
        DataAddress = 16'h0200; ReadMem = 1'b1; write = 1'b1; writeReg = 4'd9;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) bubble();
            if (ramIf.ram_re) reCnt++;
            else break;
            vecs++; if (mem_err !== 1'b0) begin
                errs++; $display("FAIL timeout_early_err got=%b exp=0 at=%0d", mem_err, i); end
        end
        vecs++; if (reCnt != 8) begin errs++; $display("FAIL timeout_len got=%0d exp=8", reCnt); end
        vecs++; if (mem_err !== 1'b1 || wb_data !== 16'h0 || wb_write !== 1'b0 || stall !== 1'b0) begin
            errs++; $display("FAIL timeout_exit got=err%b/%h/%b/stall%b exp=1/0000/0/0", mem_err,
                             wb_data, wb_write, stall); end
        tick();
        vecs++; if (mem_err !== 1'b0) begin errs++; $display("FAIL timeout_pulse got=%b exp=0", mem_err); end
    endtask

    task automatic test_illegal();
        DataAddress = 16'h0300; ReadMem = 1'b1; WriteMem = 1'b1; write = 1'b1; writeReg = 4'd2;
        ramIf.ram_rdata = 16'h1111;
        tick();
        vecs++; if (ramIf.ram_re !== 1'b1 || ramIf.ram_we !== 1'b0 || mem_err !== 1'b1) begin
            errs++; $display("FAIL illegal_req got=re%b/we%b/err%b exp=1/0/1", ramIf.ram_re,
                             ramIf.ram_we, mem_err); end
        ramIf.ram_ready = 1'b1;
        bubble();
        tick();
        ramIf.ram_ready = 1'b0;
        vecs++; if (mem_err !== 1'b0 || wb_data !== 16'h1111 || wb_writeReg !== 4'd2) begin
            errs++; $display("FAIL illegal_done got=err%b/%h/%0d exp=0/1111/2", mem_err, wb_data,
                             wb_writeReg); end
    endtask

    task automatic test_async_reset();
        DataAddress = 16'h0400; ReadMem = 1'b1; write = 1'b1; writeReg = 4'd4; quarter = 2'd3;
        tick();
        tick();
        vecs++; if (ramIf.ram_re !== 1'b1) begin errs++; $display("FAIL arst_pre got=%b exp=1", ramIf.ram_re); end
        #2;
        rst_n = 1'b0;
        #1;
        vecs++; if (ramIf.ram_re !== 1'b0 || stall !== 1'b0) begin
            errs++; $display("FAIL arst_abort got=re%b/stall%b exp=0/0", ramIf.ram_re, stall); end
        vecs++; if ({wb_data, wb_quarter, wb_write, wb_writeReg} !== '0) begin
            errs++; $display("FAIL arst_wb got=%h/%h/%b/%h exp=0", wb_data, wb_quarter, wb_write,
                             wb_writeReg); end
        bubble();
        tick();
        rst_n = 1'b1;
        DataAddress = 16'h0500; ReadMem = 1'b1; write = 1'b1; writeReg = 4'd6;
        ramIf.ram_rdata = 16'hCAFE;
        tick();
        ramIf.ram_ready = 1'b1;
        bubble();
        tick();
        ramIf.ram_ready = 1'b0;
        vecs++; if (wb_data !== 16'hCAFE || wb_write !== 1'b1 || wb_writeReg !== 4'd6) begin
            errs++; $display("FAIL arst_reload got=%h/%b/%0d exp=cafe/1/6", wb_data, wb_write,
                             wb_writeReg); end
    endtask

    task automatic test_back_to_back();
        // ready held high throughout; the IDLE request cycle must ignore it
        DataAddress = 16'h0600; ReadMem = 1'b1; write = 1'b1; writeReg = 4'd1;
        ramIf.ram_ready = 1'b1; ramIf.ram_rdata = 16'h0A0A;
        tick();
        vecs++; if (ramIf.ram_re !== 1'b1 || ramIf.ram_addr !== 16'h0600) begin
            errs++; $display("FAIL b2b_first got=re%b/%h exp=1/0600", ramIf.ram_re, ramIf.ram_addr); end
        DataAddress = 16'h0700; writeReg = 4'd2;
        tick();
        vecs++; if (wb_data !== 16'h0A0A || wb_writeReg !== 4'd1 || ramIf.ram_re !== 1'b0 ||
                    stall !== 1'b1) begin
            errs++; $display("FAIL b2b_gap got=%h/%0d/re%b/stall%b exp=0a0a/1/0/1", wb_data,
                             wb_writeReg, ramIf.ram_re, stall); end
        ramIf.ram_rdata = 16'h0B0B;
        tick();
        vecs++; if (ramIf.ram_re !== 1'b1 || ramIf.ram_addr !== 16'h0700) begin
            errs++; $display("FAIL b2b_second got=re%b/%h exp=1/0700", ramIf.ram_re, ramIf.ram_addr); end
        bubble();
        tick();
        ramIf.ram_ready = 1'b0;
        vecs++; if (wb_data !== 16'h0B0B || wb_writeReg !== 4'd2 || stall !== 1'b0) begin
            errs++; $display("FAIL b2b_done got=%h/%0d/stall%b exp=0b0b/2/0", wb_data, wb_writeReg,
                             stall); end
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_load_wait();
        test_store();
        test_timeout();
        test_illegal();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench did not finish");
    end
endmodule
